// File: rtl/game_timer_scheduler.sv
// Game minute clock and professor quiz-call scheduler for the game-state controller.
// Optional build macro QUIZ_FIXED_GAP_EN: fixed QUIZ_MIN_GAP call spacing, no LFSR.
module game_timer_scheduler #(
    parameter int unsigned TICKS_PER_MIN = 6000000,
    parameter int unsigned MAX_MIN       = 120,
    parameter int unsigned QUIZ_MIN_GAP  = 10,
    parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       start,
    input  logic       ack,
    input  logic       pause,
    input  logic       in_quiz,
    output logic [7:0] minutes,
    output logic       min_tick,
    output logic       professor,
    output logic       time_up,
    output logic [2:0] sched_state
);

    // state  | meaning
    // S_IDLE | waiting for start, minutes held at 0
    // S_RUN  | game clock running, no call pending
    // S_CALL | professor call raised, waiting for the controller to enter a quiz
    // S_QUIZ | quiz in progress, waiting for in_quiz to fall
    // S_DONE | time is up, minutes frozen until ack
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RUN  = 3'd1,
        S_CALL = 3'd2,
        S_QUIZ = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam int          PS_W    = (TICKS_PER_MIN > 1) ? $clog2(TICKS_PER_MIN) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICKS_PER_MIN - 1);
    localparam logic [8:0]  MAX9    = (MAX_MIN > 511) ? 9'd511 : 9'(MAX_MIN);
    localparam logic [8:0]  GAP_MIN = 9'(QUIZ_MIN_GAP);

    state_t          state;
    logic [PS_W-1:0] prescaler;
    logic [7:0]      next_call;
    logic [8:0]      gap;
    logic [8:0]      call_sum;
    logic [7:0]      call_load;
    logic [7:0]      minutes_inc;
    logic            counting;
    logic            wrap;
    logic            at_max;

`ifdef QUIZ_FIXED_GAP_EN
    assign gap = GAP_MIN;
`else
    localparam logic [7:0] SEED = (LFSR_SEED == 8'h00) ? 8'hA5 : LFSR_SEED;
    logic [7:0] lfsr;

    // Right-shifting Galois form of x^8+x^6+x^5+x^4+1; free-runs in every state.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            lfsr <= SEED;
        end else begin
            lfsr <= lfsr[0] ? ((lfsr >> 1) ^ 8'hB8) : (lfsr >> 1);
        end
    end

    assign gap = GAP_MIN + {5'd0, lfsr[3:0]};
`endif

    assign call_sum    = {1'b0, minutes} + gap;
    assign call_load   = call_sum[8] ? 8'hFF : call_sum[7:0];
    assign minutes_inc = (minutes == 8'hFF) ? 8'hFF : minutes + 8'd1;
    assign counting    = ((state == S_RUN) || (state == S_CALL) || (state == S_QUIZ)) && !pause;
    assign wrap        = counting && (prescaler == PS_LAST);
    assign at_max      = ({1'b0, minutes} >= MAX9);
    assign sched_state = state;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= S_IDLE;
            prescaler <= '0;
            minutes   <= 8'd0;
            min_tick  <= 1'b0;
            professor <= 1'b0;
            time_up   <= 1'b0;
            next_call <= 8'd0;
        end else begin
            min_tick <= wrap;
            if (counting) begin
                prescaler <= wrap ? '0 : prescaler + PS_W'(1);
            end
            if (wrap) begin
                minutes <= minutes_inc;
            end

            case (state)
                S_IDLE: begin
                    minutes   <= 8'd0;
                    prescaler <= '0;
                    professor <= 1'b0;
                    time_up   <= 1'b0;
                    if (start) begin
                        state     <= S_RUN;
                        next_call <= call_load;
                    end
                end
                S_RUN: begin
                    if (at_max) begin
                        state   <= S_DONE;
                        time_up <= 1'b1;
                    end else if (minutes >= next_call) begin
                        state     <= S_CALL;
                        professor <= 1'b1;
                    end
                end
                S_CALL: begin
                    if (in_quiz) begin
                        state     <= S_QUIZ;
                        professor <= 1'b0;
                    end else if (at_max) begin
                        state     <= S_DONE;
                        professor <= 1'b0;
                        time_up   <= 1'b1;
                    end
                end
                S_QUIZ: begin
                    // The final quiz is allowed to run past MAX_MIN; time_up waits for its exit.
                    professor <= 1'b0;
                    if (!in_quiz) begin
                        if (at_max) begin
                            state   <= S_DONE;
                            time_up <= 1'b1;
                        end else begin
                            state     <= S_RUN;
                            next_call <= call_load;
                        end
                    end
                end
                S_DONE: begin
                    professor <= 1'b0;
                    time_up   <= 1'b1;
                    if (ack) begin
                        state     <= S_IDLE;
                        minutes   <= 8'd0;
                        prescaler <= '0;
                        time_up   <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_timer_scheduler.sv
// Self-checking bench for game_timer_scheduler: pause table, random-pause minute model,
// LFSR call-gap handshake, quiz overrun past MAX_MIN and asynchronous reset.
module tb_game_timer_scheduler;

    localparam int T = 4;
    localparam int A_MAX = 120;

    logic       Clk;
    logic       Reset_n;
    logic       pause;
    logic       a_start, a_ack, a_in_quiz;
    logic [7:0] a_minutes;
    logic       a_min_tick, a_professor, a_time_up;
    logic [2:0] a_sched_state;
    logic       b_start, b_ack, b_in_quiz;
    logic [7:0] b_minutes;
    logic       b_min_tick, b_professor, b_time_up;
    logic [2:0] b_sched_state;

    int n_tests = 0;
    int n_fail  = 0;

    game_timer_scheduler #(.TICKS_PER_MIN(T), .MAX_MIN(A_MAX), .QUIZ_MIN_GAP(10), .LFSR_SEED(8'hA5)) dut_a (
        .Clk(Clk), .Reset_n(Reset_n), .start(a_start), .ack(a_ack), .pause(pause), .in_quiz(a_in_quiz),
        .minutes(a_minutes), .min_tick(a_min_tick), .professor(a_professor), .time_up(a_time_up),
        .sched_state(a_sched_state)
    );

    game_timer_scheduler #(.TICKS_PER_MIN(T), .MAX_MIN(20), .QUIZ_MIN_GAP(3), .LFSR_SEED(8'h3C)) dut_b (
        .Clk(Clk), .Reset_n(Reset_n), .start(b_start), .ack(b_ack), .pause(pause), .in_quiz(b_in_quiz),
        .minutes(b_minutes), .min_tick(b_min_tick), .professor(b_professor), .time_up(b_time_up),
        .sched_state(b_sched_state)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic pause;
        int   cycles;
        int   exp_minutes;
        int   exp_ticks;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_tests++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic pulse_reset();
        Reset_n = 1'b0;
        #2;
        Reset_n = 1'b1;
        tick();
    endtask

    initial begin
        vec_t vecs[6];
        int ticks, act, pre_min, exp_min, lo, hi, ref_min, calls, cnt, hold, cycles;
        logic p, running, tu_exp, tick_exp, cnt_en, seen_call;

        vecs[0] = '{1'b0, 12, 3, 3};
        vecs[1] = '{1'b0,  2, 3, 0};
        vecs[2] = '{1'b1, 20, 3, 0};
        vecs[3] = '{1'b0,  2, 4, 1};
        vecs[4] = '{1'b1,  5, 4, 0};
        vecs[5] = '{1'b0,  8, 6, 2};

`ifdef QUIZ_FIXED_GAP_EN
        lo = 10; hi = 10;
`else
        lo = 10; hi = 25;
`endif

        Reset_n = 1'b0;
        pause = 1'b0;
        a_start = 1'b0; a_ack = 1'b0; a_in_quiz = 1'b0;
        b_start = 1'b0; b_ack = 1'b0; b_in_quiz = 1'b0;
        repeat (2) @(posedge Clk);
        #2;
        check("reset_minutes", a_minutes, 0);
        check("reset_state", a_sched_state, 0);
        check("reset_professor", a_professor, 0);
        check("reset_time_up", a_time_up, 0);
        check("reset_min_tick", a_min_tick, 0);
        Reset_n = 1'b1;
        tick();
        check("idle_hold_minutes", a_minutes, 0);

        // start and ack together in idle: start wins
        a_start = 1'b1; a_ack = 1'b1;
        tick();
        a_start = 1'b0; a_ack = 1'b0;
        check("start_ack_state", a_sched_state, 1);

        foreach (vecs[i]) begin
            pause = vecs[i].pause;
            ticks = 0;
            for (int c = 0; c < vecs[i].cycles; c++) begin
                tick();
                ticks += a_min_tick;
            end
            check($sformatf("vec%0d_minutes", i), a_minutes, vecs[i].exp_minutes);
            check($sformatf("vec%0d_ticks", i), ticks, vecs[i].exp_ticks);
        end

        // Random pause: minutes = counted cycles / T until MAX_MIN ends the game
        act = 24; running = 1'b1; tu_exp = 1'b0; seen_call = 1'b0; cycles = 0;
        while ((running || cycles < 3) && cycles < 3000) begin
            if (!running) cycles++;
            else if (cycles == 0) cycles = 0;
            pre_min = (act / T > 255) ? 255 : act / T;
            p = ($urandom_range(0, 3) == 0);
            pause = p;
            tick();
            cnt_en = running && !p;
            if (cnt_en) act++;
            tick_exp = cnt_en && (act % T == 0);
            if (running && pre_min >= A_MAX) begin
                running = 1'b0;
                tu_exp = 1'b1;
            end
            exp_min = (act / T > 255) ? 255 : act / T;
            check("rand_minutes", a_minutes, exp_min);
            check("rand_min_tick", a_min_tick, tick_exp);
            check("rand_time_up", a_time_up, tu_exp);
            if (a_professor && !seen_call) begin
                seen_call = 1'b1;
                check_range("first_call_minute", a_minutes, lo, hi);
            end
            if (running && act > 2000) begin
                check("rand_timeout", 0, 1);
                running = 1'b0;
            end
        end
        pause = 1'b0;
        check("done_state", a_sched_state, 4);
        check("done_minutes", a_minutes, A_MAX);
        check("done_professor", a_professor, 0);
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        check("done_ignores_start", a_sched_state, 4);
        a_ack = 1'b1;
        tick();
        a_ack = 1'b0;
        check("ack_state", a_sched_state, 0);
        check("ack_minutes", a_minutes, 0);
        check("ack_time_up", a_time_up, 0);

        // 50 calls: gap from quiz exit (or game start) to professor lies in lo..hi
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        ref_min = 0; calls = 0; cycles = 0;
        while (calls < 50 && cycles < 40000) begin
            cnt = 0;
            while (!a_professor && a_sched_state != 3'd4 && cnt < 300) begin
                tick();
                cnt++;
            end
            cycles += cnt;
            if (cnt >= 300) begin
                check("call_wait_timeout", 0, 1);
                break;
            end
            if (a_sched_state == 3'd4) begin
                a_ack = 1'b1;
                tick();
                a_ack = 1'b0;
                a_start = 1'b1;
                tick();
                a_start = 1'b0;
                ref_min = 0;
                cycles += 2;
                continue;
            end
            check_range("call_gap", a_minutes - ref_min, lo, hi);
            calls++;
            a_in_quiz = 1'b1;
            tick();
            check("quiz_professor_drop", a_professor, 0);
            check("quiz_state", a_sched_state, 3);
            hold = $urandom_range(1, 12);
            for (int h = 0; h < hold; h++) begin
                tick();
                check("quiz_no_call", a_professor, 0);
            end
            ref_min = a_minutes;
            a_in_quiz = 1'b0;
            tick();
            cycles += hold + 2;
        end
        check("calls_made", calls, 50);
        a_in_quiz = 1'b0;

        // Second instance: MAX_MIN=20, quiz from minute 18 through 24 overruns the limit
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        cnt = 0;
        while (!(b_professor && b_minutes >= 18) && cnt < 200) begin
            tick();
            cnt++;
        end
        check("b_call_minute", b_minutes, 18);
        b_in_quiz = 1'b1;
        tick();
        check("b_quiz_state", b_sched_state, 3);
        cnt = 0;
        while (b_minutes < 24 && cnt < 100) begin
            check("b_no_time_up_in_quiz", b_time_up, 0);
            tick();
            cnt++;
        end
        check("b_quiz_minutes", b_minutes, 24);
        b_in_quiz = 1'b0;
        tick();
        check("b_done_state", b_sched_state, 4);
        check("b_done_time_up", b_time_up, 1);
        check("b_done_minutes", b_minutes, 24);
        repeat (8) tick();
        check("b_frozen_minutes", b_minutes, 24);
        b_ack = 1'b1;
        tick();
        b_ack = 1'b0;
        check("b_ack_minutes", b_minutes, 0);
        check("b_ack_state", b_sched_state, 0);
        check("b_ack_time_up", b_time_up, 0);

        // Asynchronous reset while a call is pending
        pulse_reset();
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        cnt = 0;
        while (!a_professor && cnt < 200) begin
            tick();
            cnt++;
        end
        check("pre_reset_call_state", a_sched_state, 2);
        #2;
        Reset_n = 1'b0;
        #1;
        check("async_professor", a_professor, 0);
        check("async_minutes", a_minutes, 0);
        check("async_state", a_sched_state, 0);
        #2;
        Reset_n = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
